// File: rtl/rv32m_pkg.sv
// Shared types and sizing helpers for the rv32m execute unit.
// Used here by the radix-2 divider.
package rv32m_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        FIXUP,
        DONE
    } div_state_t;

    localparam int DIV_NUM_BITS = 32;
    localparam int DIV_CNT_W    = $clog2(DIV_NUM_BITS + 1);

    function automatic int cnt_width(input int num_bits);
        return $clog2(num_bits + 1);
    endfunction

endpackage

// File: rtl/divider_step.sv
// One radix-2 restoring iteration: shift {rem, quo} left, then trial-subtract the divisor.
// Kept combinational so it can be chained for higher-radix unrolling.
module divider_step #(
    parameter int NUM_BITS = 32
) (
    input  logic [NUM_BITS-1:0] rem,
    input  logic [NUM_BITS-1:0] quo,
    input  logic [NUM_BITS-1:0] divisor,
    output logic [NUM_BITS-1:0] rem_next,
    output logic [NUM_BITS-1:0] quo_next
);

    logic [NUM_BITS:0] shifted;
    logic [NUM_BITS:0] trial;

    // The shifted remainder can reach 2*divisor-1, so the trial needs one extra bit.
    always_comb begin
        shifted  = {rem, quo[NUM_BITS-1]};
        trial    = shifted - {1'b0, divisor};
        rem_next = trial[NUM_BITS] ? shifted[NUM_BITS-1:0] : trial[NUM_BITS-1:0];
        quo_next = {quo[NUM_BITS-2:0], ~trial[NUM_BITS]};
    end

endmodule

// File: rtl/radix2_divider.sv
// Sequential radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Works on magnitudes, one quotient bit per cycle, sign-corrected in a final FIXUP cycle.
module radix2_divider
    import rv32m_pkg::*;
#(
    parameter int NUM_BITS = DIV_NUM_BITS
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                start,
    input  logic                is_signed,
    input  logic [NUM_BITS-1:0] dividend,
    input  logic [NUM_BITS-1:0] divisor,
    output logic [NUM_BITS-1:0] quotient,
    output logic [NUM_BITS-1:0] remainder,
    output logic                finished,
    output div_state_t          state
);

    localparam int CNT_W = cnt_width(NUM_BITS);
    localparam logic [NUM_BITS-1:0] MIN_NEG = {1'b1, {(NUM_BITS-1){1'b0}}};

    div_state_t          next_state;
    logic                accept;
    logic                div_zero;
    logic                overflow;
    logic [NUM_BITS-1:0] abs_dividend;
    logic [NUM_BITS-1:0] abs_divisor;
    logic [NUM_BITS-1:0] rem_r;
    logic [NUM_BITS-1:0] quo_r;
    logic [NUM_BITS-1:0] div_r;
    logic [NUM_BITS-1:0] rem_step;
    logic [NUM_BITS-1:0] quo_step;
    logic [CNT_W-1:0]    cnt;
    logic                neg_q;
    logic                neg_r;

    assign div_zero     = (divisor == '0);
    assign overflow     = is_signed && (dividend == MIN_NEG) && (divisor == '1);
    assign abs_dividend = (is_signed && dividend[NUM_BITS-1]) ? -dividend : dividend;
    assign abs_divisor  = (is_signed && divisor[NUM_BITS-1])  ? -divisor  : divisor;

    divider_step #(
        .NUM_BITS(NUM_BITS)
    ) u_step (
        .rem      (rem_r),
        .quo      (quo_r),
        .divisor  (div_r),
        .rem_next (rem_step),
        .quo_next (quo_step)
    );

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // start is only honoured when no division is in flight.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = (div_zero || overflow) ? DONE : DIVIDE;
                end
            end
            DIVIDE: begin
                if (cnt == CNT_W'(1)) begin
                    next_state = FIXUP;
                end
            end
            FIXUP:   next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            quotient  <= '0;
            remainder <= '0;
            finished  <= 1'b0;
            cnt       <= '0;
            rem_r     <= '0;
            quo_r     <= '0;
            div_r     <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
        end else if (accept) begin
            finished <= 1'b0;
            neg_q    <= is_signed && (dividend[NUM_BITS-1] ^ divisor[NUM_BITS-1]);
            neg_r    <= is_signed && dividend[NUM_BITS-1];
            if (div_zero) begin
                quotient  <= '1;
                remainder <= dividend;
                finished  <= 1'b1;
            end else if (overflow) begin
                quotient  <= dividend;
                remainder <= '0;
                finished  <= 1'b1;
            end else begin
                rem_r <= '0;
                quo_r <= abs_dividend;
                div_r <= abs_divisor;
                cnt   <= CNT_W'(NUM_BITS);
            end
        end else if (state == DIVIDE) begin
            rem_r <= rem_step;
            quo_r <= quo_step;
            cnt   <= cnt - CNT_W'(1);
        end else if (state == FIXUP) begin
            quotient  <= neg_q ? -quo_r : quo_r;
            remainder <= neg_r ? -rem_r : rem_r;
            finished  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_radix2_divider.sv
// Self-checking bench for radix2_divider: directed cases plus randomized operands
// compared against a plain-arithmetic RISC-V division model.
module tb_radix2_divider;
    import rv32m_pkg::*;

    logic        CLK;
    logic        nRST;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        finished;
    div_state_t  state;

    int checks   = 0;
    int failures = 0;

    radix2_divider #(
        .NUM_BITS(32)
    ) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .finished  (finished),
        .state     (state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // RISC-V M semantics: truncating division, remainder takes dividend's sign.
    task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           output logic [31:0] q, output logic [31:0] r, output int lat);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            lat = 1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = 32'd0;
            lat = 1;
        end else if (s) begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
            lat = 34;
        end else begin
            q = a / b;
            r = a % b;
            lat = 34;
        end
    endtask

    // Counts edges until finished rises; start has already been driven.
    task automatic wait_done(input string tag, output int lat);
        lat = 0;
        while (lat < 100) begin
            @(posedge CLK);
            #1;
            start = 1'b0;
            lat++;
            if (finished) break;
        end
        if (!finished) begin
            failures++;
            checks++;
            $error("FAIL %s_timeout: got finished=0 expected finished=1 within 100 edges", tag);
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input string tag);
        logic [31:0] eq;
        logic [31:0] er;
        int          el;
        int          lat;
        ref_div(a, b, s, eq, er, el);
        @(negedge CLK);
        dividend  = a;
        divisor   = b;
        is_signed = s;
        start     = 1'b1;
        wait_done(tag, lat);
        check({tag, "_lat"}, 32'(lat), 32'(el));
        check({tag, "_q"}, quotient, eq);
        check({tag, "_r"}, remainder, er);
    endtask

    initial begin
        int          lat;
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        int          pick;

        nRST      = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_finished", 32'(finished), 32'd0);
        check("rst_q", quotient, 32'd0);
        check("rst_r", remainder, 32'd0);
        check("rst_state", 32'(state), 32'(IDLE));
        @(negedge CLK);
        nRST = 1'b1;

        run_op(32'd100, 32'd7, 1'b0, "udiv_100_7");
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, "sdiv_m7_2");
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, "sdiv_7_m2");
        run_op(32'h1234, 32'd0, 1'b0, "divz_u");
        run_op(32'h1234, 32'd0, 1'b1, "divz_s");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "ovf_s");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "msb_u");

        // start pulsed mid-division must be ignored
        @(negedge CLK);
        dividend  = 32'd50;
        divisor   = 32'd5;
        is_signed = 1'b0;
        start     = 1'b1;
        lat = 0;
        while (lat < 100) begin
            @(posedge CLK);
            #1;
            lat++;
            start = 1'b0;
            if (finished) break;
            if (lat == 9) begin
                dividend = 32'd9;
                divisor  = 32'd3;
                start    = 1'b1;
            end
        end
        check("busy_lat", 32'(lat), 32'd34);
        check("busy_q", quotient, 32'd10);
        check("busy_r", remainder, 32'd0);

        // back-to-back start straight out of DONE
        dividend = 32'd9;
        divisor  = 32'd3;
        start    = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        check("b2b_finished_drop", 32'(finished), 32'd0);
        wait_done("b2b", lat);
        check("b2b_lat", 32'(lat + 1), 32'd34);
        check("b2b_q", quotient, 32'd3);
        check("b2b_r", remainder, 32'd0);

        // reset in the middle of a division
        @(negedge CLK);
        dividend = 32'd5000;
        divisor  = 32'd7;
        start    = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        repeat (11) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b0;
        @(posedge CLK);
        #1;
        check("midrst_finished", 32'(finished), 32'd0);
        check("midrst_q", quotient, 32'd0);
        check("midrst_r", remainder, 32'd0);
        check("midrst_state", 32'(state), 32'(IDLE));
        @(negedge CLK);
        nRST = 1'b1;
        run_op(32'd1000, 32'd33, 1'b0, "post_rst");

        for (int i = 0; i < 40; i++) begin
            a    = $urandom;
            s    = 1'($urandom_range(0, 1));
            pick = $urandom_range(0, 9);
            if (pick == 0) begin
                b = 32'd0;
            end else if (pick == 1) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end else if (pick == 2) begin
                b = 32'($urandom_range(1, 15));
            end else begin
                b = $urandom >> $urandom_range(0, 31);
            end
            run_op(a, b, s, $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
